fft32_addr_seq: RTL and testbench

- Sequencer for the in-place 32-point radix-2 DIT FFT.
- Walks stages 0..4 and, in each stage, butterflies 0..15.
- Emits the read/write address pair, the twiddle ROM address and the stage select for every butterfly.
- Sits directly upstream of the 5-bit left-rotate address stage: stage_sel drives its S input and addr_a drives its in input, one butterfly per accepted cycle.

---
 rtl/fft32_pkg.sv | 27 ++
 rtl/fft32_bfly_addr_calc.sv | 30 +++
 rtl/fft32_addr_seq.sv | 144 ++++++++++++++
 tb/tb_fft32_addr_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft32_pkg.sv
// Shared constants, state encoding and field types for the 32-point FFT address sequencer.
package fft32_pkg;

   localparam int unsigned LOG2N      = 5;
   localparam int unsigned N          = 32;
   localparam int unsigned NUM_BFLY   = 16;
   localparam int unsigned NUM_STAGES = 5;

   localparam int unsigned STAGE_W = 3;
   localparam int unsigned BFLY_W  = 4;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned TW_W    = 4;
   localparam int unsigned GAP_W   = 3;

   typedef logic [STAGE_W-1:0] stage_t;
   typedef logic [BFLY_W-1:0]  bfly_t;
   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [TW_W-1:0]    tw_t;
   typedef logic [GAP_W-1:0]   gap_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/fft32_bfly_addr_calc.sv
// Combinational (stage, j) -> butterfly address pair and twiddle index for a radix-2 DIT pass.
module fft32_bfly_addr_calc
   import fft32_pkg::*;
(
   input  logic [STAGE_W-1:0] stage,
   input  logic [BFLY_W-1:0]  j,
   output logic [ADDR_W-1:0]  addr_a,
   output logic [ADDR_W-1:0]  addr_b,
   output logic [TW_W-1:0]    tw_addr
);

   logic [ADDR_W-1:0]  jw;
   logic [ADDR_W-1:0]  span;
   logic [ADDR_W-1:0]  lo_mask;
   logic [ADDR_W-1:0]  pos;
   logic [STAGE_W-1:0] tw_shift;

   // Inserting a zero at bit s of j gives the upper address; the lower one sets that bit.
   always_comb begin
      jw       = ADDR_W'(j);
      span     = ADDR_W'(1) << stage;
      lo_mask  = span - ADDR_W'(1);
      pos      = jw & lo_mask;
      tw_shift = STAGE_W'(3'd4 - stage);
      addr_a   = ((jw & ~lo_mask) << 1'b1) | pos;
      addr_b   = addr_a | span;
      tw_addr  = TW_W'(pos << tw_shift);
   end

endmodule

// File: rtl/fft32_addr_seq.sv
// Stage/butterfly sequencer for an in-place 32-point radix-2 DIT FFT with inter-stage bubbles.
module fft32_addr_seq #(
   parameter int unsigned LOG2N     = 5,
   parameter int unsigned STAGE_GAP = 2
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         start,
   input  logic                         adv,
   output logic                         valid,
   output logic [fft32_pkg::STAGE_W-1:0] stage_sel,
   output logic [fft32_pkg::BFLY_W-1:0]  bfly_idx,
   output logic [fft32_pkg::ADDR_W-1:0]  addr_a,
   output logic [fft32_pkg::ADDR_W-1:0]  addr_b,
   output logic [fft32_pkg::TW_W-1:0]    tw_addr,
   output logic                         busy,
   output logic                         done
);
   import fft32_pkg::*;

   localparam stage_t LAST_STAGE = STAGE_W'(LOG2N - 1);
   localparam bfly_t  LAST_BFLY  = BFLY_W'(NUM_BFLY - 1);
   localparam gap_t   GAP_LOAD   = GAP_W'(STAGE_GAP - 1);

   state_t state, state_nx;
   gap_t   gap_cnt, gap_nx;
   stage_t stage_nx;
   bfly_t  j_nx;
   logic   valid_nx, busy_nx, done_nx;
   addr_t  calc_a, calc_b, a_nx, b_nx;
   tw_t    calc_tw, tw_nx;
   logic   accept, last_bfly, last_stage;

   assign accept     = valid & adv;
   assign last_bfly  = (bfly_idx == LAST_BFLY);
   assign last_stage = (stage_sel == LAST_STAGE);

   // State register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            if (accept && last_bfly) begin
               if (last_stage)          state_nx = IDLE;
               else if (STAGE_GAP != 0) state_nx = GAP;
            end
         end
         GAP:     if (gap_cnt == '0) state_nx = RUN;
         default: state_nx = IDLE;
      endcase
   end

   // Next values of the registered outputs and the gap counter.
   always_comb begin
      stage_nx = stage_sel;
      j_nx     = bfly_idx;
      gap_nx   = gap_cnt;
      valid_nx = valid;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               stage_nx = '0;
               j_nx     = '0;
               valid_nx = 1'b1;
            end
         end
         RUN: begin
            if (accept) begin
               if (!last_bfly) begin
                  j_nx = bfly_t'(bfly_idx + 1'b1);
               end else if (last_stage) begin
                  valid_nx = 1'b0;
                  done_nx  = 1'b1;
               end else if (STAGE_GAP != 0) begin
                  valid_nx = 1'b0;
                  gap_nx   = GAP_LOAD;
               end else begin
                  stage_nx = stage_t'(stage_sel + 1'b1);
                  j_nx     = '0;
               end
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               stage_nx = stage_t'(stage_sel + 1'b1);
               j_nx     = '0;
               valid_nx = 1'b1;
            end else begin
               gap_nx = gap_t'(gap_cnt - 1'b1);
            end
         end
         default: begin
            valid_nx = 1'b0;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   fft32_bfly_addr_calc u_calc (
      .stage   (stage_nx),
      .j       (j_nx),
      .addr_a  (calc_a),
      .addr_b  (calc_b),
      .tw_addr (calc_tw)
   );

   // Addresses load only alongside a valid butterfly; otherwise they keep their last value.
   assign a_nx  = valid_nx ? calc_a  : addr_a;
   assign b_nx  = valid_nx ? calc_b  : addr_b;
   assign tw_nx = valid_nx ? calc_tw : tw_addr;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         gap_cnt   <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         stage_sel <= '0;
         bfly_idx  <= '0;
         addr_a    <= '0;
         addr_b    <= '0;
         tw_addr   <= '0;
      end else begin
         gap_cnt   <= gap_nx;
         valid     <= valid_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         stage_sel <= stage_nx;
         bfly_idx  <= j_nx;
         addr_a    <= a_nx;
         addr_b    <= b_nx;
         tw_addr   <= tw_nx;
      end
   end

endmodule

// File: tb/tb_fft32_addr_seq.sv
// Bench for fft32_addr_seq: butterfly-list reference model plus directed timing scenarios.
module tb_fft32_addr_seq;

   localparam int NB = 80;

   logic       clk = 1'b0;
   logic       clr;
   logic [1:0] start, adv, valid, busy, done;
   logic [2:0] stage_o [2];
   logic [3:0] j_o     [2];
   logic [4:0] a_o     [2];
   logic [4:0] b_o     [2];
   logic [3:0] tw_o    [2];

   always #5 clk = ~clk;

   fft32_addr_seq #(.LOG2N(5), .STAGE_GAP(2)) dut_g2 (
      .clk(clk), .clr(clr), .start(start[0]), .adv(adv[0]), .valid(valid[0]),
      .stage_sel(stage_o[0]), .bfly_idx(j_o[0]), .addr_a(a_o[0]), .addr_b(b_o[0]),
      .tw_addr(tw_o[0]), .busy(busy[0]), .done(done[0]));

   fft32_addr_seq #(.LOG2N(5), .STAGE_GAP(0)) dut_g0 (
      .clk(clk), .clr(clr), .start(start[1]), .adv(adv[1]), .valid(valid[1]),
      .stage_sel(stage_o[1]), .bfly_idx(j_o[1]), .addr_a(a_o[1]), .addr_b(b_o[1]),
      .tw_addr(tw_o[1]), .busy(busy[1]), .done(done[1]));

   typedef struct {int s; int j; int a; int b; int tw;} bf_t;
   bf_t exp_list [NB];

   int tests = 0;
   int fails = 0;
   int ecnt  = 0;
   int k [2];
   int done_cnt [2];
   int done_rel [2];
   int busy_cnt [2];
   int valid_cnt [2];
   int gap_cnt [2];
   int start_ref [2];

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Butterfly order of a pass: each stage pairs x[g*2*span+p] with x[g*2*span+p+span].
   task automatic build_model();
      int idx = 0;
      for (int s = 0; s < 5; s++) begin
         int span = 1 << s;
         for (int g = 0; g < 16 / span; g++)
            for (int p = 0; p < span; p++) begin
               exp_list[idx] = '{s, g * span + p, g * 2 * span + p, g * 2 * span + p + span, p * (16 / span)};
               idx++;
            end
      end
   endtask

   // Per-cycle comparison of every valid butterfly against the reference list.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (clr) begin
            k[d] = 0;
         end else begin
            if (valid[d]) begin
               if (k[d] >= NB) begin
                  chk("bfly_overrun", k[d], NB - 1);
               end else begin
                  chk("bfly_stage", int'(stage_o[d]), exp_list[k[d]].s);
                  chk("bfly_j",     int'(j_o[d]),     exp_list[k[d]].j);
                  chk("bfly_a",     int'(a_o[d]),     exp_list[k[d]].a);
                  chk("bfly_b",     int'(b_o[d]),     exp_list[k[d]].b);
                  chk("bfly_tw",    int'(tw_o[d]),    exp_list[k[d]].tw);
               end
               valid_cnt[d]++;
               if (adv[d]) k[d]++;
            end
            if (busy[d]) busy_cnt[d]++;
            if (busy[d] && !valid[d]) gap_cnt[d]++;
            if (done[d]) begin
               done_cnt[d]++;
               done_rel[d] = ecnt - start_ref[d];
               chk("done_busy_low", int'(busy[d]), 0);
               chk("done_complete", k[d], NB);
               k[d] = 0;
            end
         end
      end
   end

   task automatic clear_stats(input int d);
      done_cnt[d] = 0; done_rel[d] = 0; busy_cnt[d] = 0;
      valid_cnt[d] = 0; gap_cnt[d] = 0; start_ref[d] = ecnt;
   endtask

   task automatic start_pass(input int d);
      @(posedge clk); #1;
      start[d] = 1'b1;
      clear_stats(d);
      @(posedge clk); #1;
      start[d] = 1'b0;
   endtask

   task automatic pulse_start(input int d);
      start[d] = 1'b1;
      @(posedge clk); #1;
      start[d] = 1'b0;
   endtask

   task automatic wait_st(input int d, input int s, input int jj, input logic v, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(posedge clk); #1;
         if (busy[d] && valid[d] == v && int'(stage_o[d]) == s && int'(j_o[d]) == jj) hit = 1'b1;
      end
      chk({"reach_", name}, int'(hit), 1);
   endtask

   task automatic wait_done(input int d);
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(posedge clk); #1;
         if (done[d]) hit = 1'b1;
      end
      chk("reach_done", int'(hit), 1);
   endtask

   task automatic chk_lit(input string name, input int d, input int a, input int b, input int tw);
      chk({name, "_valid"}, int'(valid[d]), 1);
      chk({name, "_a"},  int'(a_o[d]),  a);
      chk({name, "_b"},  int'(b_o[d]),  b);
      chk({name, "_tw"}, int'(tw_o[d]), tw);
   endtask

   task automatic chk_zero(input string name, input int d);
      chk(name, int'({valid[d], busy[d], done[d], stage_o[d], j_o[d], a_o[d], b_o[d], tw_o[d]}), 0);
   endtask

   task automatic end_pass(input int d, input int rel, input int nvalid, input int ngap);
      chk("done_cycle", done_rel[d], rel);
      chk("done_pulses", done_cnt[d], 1);
      chk("valid_cycles", valid_cnt[d], nvalid);
      chk("busy_cycles", busy_cnt[d], rel - 1);
      chk("gap_cycles", gap_cnt[d], ngap);
   endtask

   initial begin
      build_model();
      clr = 1'b1; start = 2'b00; adv = 2'b11;
      k[0] = 0; k[1] = 0;
      clear_stats(0); clear_stats(1);
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset_g2", 0);
      chk_zero("reset_g0", 1);
      clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("idle_g2", 0);
      chk_zero("idle_g0", 1);

      // Pass with a 3-cycle stall at stage 1, j=6.
      start_pass(0);
      chk_lit("first", 0, 0, 1, 0);
      chk("first_stage", int'(stage_o[0]), 0);
      wait_st(0, 1, 6, 1'b1, "s1j6");
      adv[0] = 1'b0;
      chk_lit("s1j6", 0, 12, 14, 0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_j", int'(j_o[0]), 6);
         chk_lit("stall", 0, 12, 14, 0);
      end
      adv[0] = 1'b1;
      @(posedge clk); #1;
      chk("after_stall_j", int'(j_o[0]), 7);
      chk_lit("s1j7", 0, 13, 15, 8);
      wait_st(0, 2, 5, 1'b1, "s2j5");
      chk_lit("s2j5", 0, 9, 13, 4);
      wait_st(0, 4, 15, 1'b1, "s4j15");
      chk_lit("s4j15", 0, 15, 31, 15);
      wait_done(0);
      @(negedge clk); #1;
      end_pass(0, 92, 83, 8);

      // Start during RUN and GAP is ignored; start in the done cycle begins a new pass.
      start_pass(0);
      wait_st(0, 0, 4, 1'b1, "s0j4");
      pulse_start(0);
      wait_st(0, 0, 15, 1'b0, "gap0");
      pulse_start(0);
      wait_done(0);
      start[0] = 1'b1;
      @(negedge clk); #1;
      end_pass(0, 89, 80, 8);
      clear_stats(0);
      @(posedge clk); #1;
      start[0] = 1'b0;
      chk("restart_stage", int'(stage_o[0]), 0);
      chk("restart_j", int'(j_o[0]), 0);
      chk_lit("restart", 0, 0, 1, 0);

      // Asynchronous clear in the gap between stages 2 and 3.
      wait_st(0, 2, 15, 1'b0, "gap2");
      clr = 1'b1;
      #1;
      chk_zero("async_clr", 0);
      @(posedge clk); #1;
      clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("no_done_after_clr", done_cnt[0], 0);
      chk_zero("idle_after_clr", 0);
      start_pass(0);
      chk("post_clr_stage", int'(stage_o[0]), 0);
      chk_lit("post_clr", 0, 0, 1, 0);
      wait_done(0);
      @(negedge clk); #1;
      end_pass(0, 89, 80, 8);

      // Zero-gap build: stages run back to back.
      start_pass(1);
      chk_lit("g0_first", 1, 0, 1, 0);
      wait_st(1, 0, 15, 1'b1, "g0_s0j15");
      chk_lit("g0_s0j15", 1, 30, 31, 0);
      @(posedge clk); #1;
      chk("g0_next_stage", int'(stage_o[1]), 1);
      chk("g0_next_j", int'(j_o[1]), 0);
      chk_lit("g0_s1j0", 1, 0, 2, 0);
      wait_done(1);
      @(negedge clk); #1;
      end_pass(1, 81, 80, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
